regfile_wb_ctrl: RTL

Initiator side of the 2-read/1-write register file port. Arbitrates two writeback producers (ALU, load unit) onto the single write port, forwards the write in flight to both read ports, and keeps a pending-write scoreboard for decode hazard checks. Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: writeback arbiter for the single register file write port.
// Arbitrates ALU (A) and load (B) producers with starvation protection for B,
// forwards the in-flight write to both read ports, and tracks pending writes.
module regfile_wb_ctrl #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned REG_FILE_SIZE = 32,
   parameter int unsigned MAX_WAIT      = 3,
   localparam int unsigned AW           = $clog2(REG_FILE_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_a_valid,
   output logic                  o_a_ready,
   input  logic [AW-1:0]         i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_data,
   input  logic                  i_b_valid,
   output logic                  o_b_ready,
   input  logic [AW-1:0]         i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_data,
   output logic                  o_rf_wen,
   output logic [AW-1:0]         o_rf_waddr,
   output logic [DATA_WIDTH-1:0] o_rf_wdata,
   input  logic [AW-1:0]         i_raddr1,
   input  logic [AW-1:0]         i_raddr2,
   output logic [AW-1:0]         o_rf_raddr1,
   output logic [AW-1:0]         o_rf_raddr2,
   input  logic [DATA_WIDTH-1:0] i_rf_rdata1,
   input  logic [DATA_WIDTH-1:0] i_rf_rdata2,
   output logic [DATA_WIDTH-1:0] o_rs1_data,
   output logic [DATA_WIDTH-1:0] o_rs2_data,
   output logic                  o_rs1_busy,
   output logic                  o_rs2_busy,
   input  logic                  i_alloc_valid,
   input  logic [AW-1:0]         i_alloc_addr
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] MaxWait = WW'(MAX_WAIT);
   localparam logic [WW-1:0] WaitOne = WW'(1);

   logic [WW-1:0]            wait_cnt_q, wait_cnt_d;
   logic [REG_FILE_SIZE-1:0] sb_q, sb_d;
   logic                     b_forced;
   logic                     grant_a, grant_b;

   // Handshake, arbitration and write port drive
   always_comb begin
      b_forced   = (wait_cnt_q == MaxWait);
      o_a_ready  = ~rst & ~(b_forced & i_b_valid);
      o_b_ready  = ~rst & (~i_a_valid | b_forced);
      grant_a    = i_a_valid & o_a_ready;
      grant_b    = i_b_valid & o_b_ready;
      o_rf_waddr = grant_b ? i_b_addr : i_a_addr;
      o_rf_wdata = grant_b ? i_b_data : i_a_data;
      // Grants to x0 complete the handshake but never reach the array
      o_rf_wen   = (grant_a | grant_b) & (o_rf_waddr != '0);
   end

   // Read pass-through, forwarding of the in-flight write, hazard flags
   always_comb begin
      o_rf_raddr1 = i_raddr1;
      o_rf_raddr2 = i_raddr2;
      o_rs1_data  = i_rf_rdata1;
      o_rs2_data  = i_rf_rdata2;
      if (o_rf_wen && (o_rf_waddr == i_raddr1) && (i_raddr1 != '0)) o_rs1_data = o_rf_wdata;
      if (o_rf_wen && (o_rf_waddr == i_raddr2) && (i_raddr2 != '0)) o_rs2_data = o_rf_wdata;
      o_rs1_busy  = sb_q[i_raddr1] & ~(o_rf_wen & (o_rf_waddr == i_raddr1));
      o_rs2_busy  = sb_q[i_raddr2] & ~(o_rf_wen & (o_rf_waddr == i_raddr2));
   end

   // Next-state for B starvation counter and pending-write scoreboard
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!i_b_valid || grant_b) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != MaxWait) begin
         wait_cnt_d = wait_cnt_q + WaitOne;
      end

      sb_d = sb_q;
      if (o_rf_wen) sb_d[o_rf_waddr] = 1'b0;
      // Applied after the clear so a same-cycle alloc keeps the bit set
      if (i_alloc_valid && (i_alloc_addr != '0)) sb_d[i_alloc_addr] = 1'b1;
      sb_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_q <= '0;
         sb_q       <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         sb_q       <= sb_d;
      end
   end

endmodule
